// File: rtl/axi_id_remap_pkg.sv
// Shared helpers for the AXI ID remapper: counter sizing and ID-width sanity check.
`default_nettype none

package axi_id_remap_pkg;

  function automatic int cnt_width(input int max_txns);
    return $clog2(max_txns + 1);
  endfunction

  function automatic bit id_width_ok(input int id_width_out, input int table_size);
    return (1 << id_width_out) >= table_size;
  endfunction

  localparam int DEFAULT_ID_WIDTH_IN = 8;
  localparam int DEFAULT_MAX_TXNS    = 8;
  localparam int DEFAULT_CNT_W       = cnt_width(DEFAULT_MAX_TXNS);

  // Slot entry at the default widths; the table builds its own at its parameter widths.
  typedef struct packed {
    logic                           valid;
    logic [DEFAULT_ID_WIDTH_IN-1:0] in_id;
    logic [DEFAULT_CNT_W-1:0]       cnt;
  } slot_t;

endpackage

`default_nettype wire

// File: rtl/axi_id_remap_table.sv
// One direction's remap table: maps in-flight wide IDs to slot indices and back.
`default_nettype none

module axi_id_remap_table
  import axi_id_remap_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 4,
  parameter int TABLE_SIZE = 4,
  parameter int MAX_TXNS   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_ready,
  input  logic [IN_W-1:0]  issue_id,
  output logic [OUT_W-1:0] issue_slot,
  output logic             stall,
  input  logic             retire_valid,
  input  logic [OUT_W-1:0] retire_slot,
  input  logic [OUT_W-1:0] lookup_slot,
  output logic [IN_W-1:0]  lookup_id
);

  localparam int CNT_W = cnt_width(MAX_TXNS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TXNS);

  typedef struct packed {
    logic             valid;
    logic [IN_W-1:0]  in_id;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  entry_t entry [TABLE_SIZE];

  logic                  hit, hit_full, free_found, retire_known, issue_fire;
  logic [OUT_W-1:0]      hit_slot, free_slot;
  logic [TABLE_SIZE-1:0] inc, dec;

  always_comb begin
    hit          = 1'b0;
    hit_full     = 1'b0;
    hit_slot     = '0;
    free_found   = 1'b0;
    free_slot    = '0;
    lookup_id    = '0;
    retire_known = 1'b0;
    // Descending scan so the lowest free index is the one left standing.
    for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
      if (!entry[i].valid) begin
        free_found = 1'b1;
        free_slot  = OUT_W'(i);
      end
    end
    for (int i = 0; i < TABLE_SIZE; i++) begin
      if (entry[i].valid && entry[i].in_id == issue_id) begin
        hit      = 1'b1;
        hit_slot = OUT_W'(i);
        hit_full = (entry[i].cnt == CNT_MAX);
      end
      if (lookup_slot == OUT_W'(i)) lookup_id = entry[i].in_id;
      if (retire_slot == OUT_W'(i) && entry[i].valid) retire_known = 1'b1;
    end
    issue_slot = hit ? hit_slot : free_slot;
    stall      = hit ? hit_full : !free_found;
    issue_fire = issue_valid && issue_ready && !stall;
    for (int i = 0; i < TABLE_SIZE; i++) begin
      inc[i] = issue_fire && (issue_slot == OUT_W'(i));
      dec[i] = retire_valid && (retire_slot == OUT_W'(i)) && entry[i].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TABLE_SIZE; i++) entry[i] <= '0;
    end else begin
      for (int i = 0; i < TABLE_SIZE; i++) begin
        if (inc[i] && !dec[i]) begin
          if (!entry[i].valid) begin
            entry[i].valid <= 1'b1;
            entry[i].in_id <= issue_id;
            entry[i].cnt   <= CNT_W'(1);
          end else begin
            entry[i].cnt <= entry[i].cnt + CNT_W'(1);
          end
        end else if (dec[i] && !inc[i]) begin
          entry[i].cnt <= entry[i].cnt - CNT_W'(1);
          if (entry[i].cnt == CNT_W'(1)) entry[i].valid <= 1'b0;
        end
      end
    end
  end

  a_retire_known_slot: assert property (@(posedge clk) disable iff (rst)
    retire_valid |-> retire_known);

endmodule

`default_nettype wire

// File: rtl/axi_id_remapper.sv
// AXI4 ID width compressor: wide upstream IDs become slot indices downstream, zero added latency.
`default_nettype none

module axi_id_remapper
  import axi_id_remap_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int USER_WIDTH   = 8,
  parameter int ID_WIDTH_IN  = 8,
  parameter int ID_WIDTH_OUT = 4,
  parameter int TABLE_SIZE   = 4,
  parameter int MAX_TXNS     = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ID_WIDTH_IN-1:0]  in_aw_id,
  input  logic [ADDR_WIDTH-1:0]   in_aw_addr,
  input  logic [7:0]              in_aw_len,
  input  logic [2:0]              in_aw_size,
  input  logic [1:0]              in_aw_burst,
  input  logic                    in_aw_lock,
  input  logic [3:0]              in_aw_cache,
  input  logic [2:0]              in_aw_prot,
  input  logic [3:0]              in_aw_qos,
  input  logic [3:0]              in_aw_region,
  input  logic [USER_WIDTH-1:0]   in_aw_user,
  input  logic                    in_aw_valid,
  output logic                    in_aw_ready,
  input  logic [DATA_WIDTH-1:0]   in_w_data,
  input  logic [DATA_WIDTH/8-1:0] in_w_strb,
  input  logic                    in_w_last,
  input  logic [USER_WIDTH-1:0]   in_w_user,
  input  logic                    in_w_valid,
  output logic                    in_w_ready,
  output logic [ID_WIDTH_IN-1:0]  in_b_id,
  output logic [1:0]              in_b_resp,
  output logic [USER_WIDTH-1:0]   in_b_user,
  output logic                    in_b_valid,
  input  logic                    in_b_ready,
  input  logic [ID_WIDTH_IN-1:0]  in_ar_id,
  input  logic [ADDR_WIDTH-1:0]   in_ar_addr,
  input  logic [7:0]              in_ar_len,
  input  logic [2:0]              in_ar_size,
  input  logic [1:0]              in_ar_burst,
  input  logic                    in_ar_lock,
  input  logic [3:0]              in_ar_cache,
  input  logic [2:0]              in_ar_prot,
  input  logic [3:0]              in_ar_qos,
  input  logic [3:0]              in_ar_region,
  input  logic [USER_WIDTH-1:0]   in_ar_user,
  input  logic                    in_ar_valid,
  output logic                    in_ar_ready,
  output logic [ID_WIDTH_IN-1:0]  in_r_id,
  output logic [DATA_WIDTH-1:0]   in_r_data,
  output logic [1:0]              in_r_resp,
  output logic                    in_r_last,
  output logic [USER_WIDTH-1:0]   in_r_user,
  output logic                    in_r_valid,
  input  logic                    in_r_ready,
  output logic [ID_WIDTH_OUT-1:0] out_aw_id,
  output logic [ADDR_WIDTH-1:0]   out_aw_addr,
  output logic [7:0]              out_aw_len,
  output logic [2:0]              out_aw_size,
  output logic [1:0]              out_aw_burst,
  output logic                    out_aw_lock,
  output logic [3:0]              out_aw_cache,
  output logic [2:0]              out_aw_prot,
  output logic [3:0]              out_aw_qos,
  output logic [3:0]              out_aw_region,
  output logic [USER_WIDTH-1:0]   out_aw_user,
  output logic                    out_aw_valid,
  input  logic                    out_aw_ready,
  output logic [DATA_WIDTH-1:0]   out_w_data,
  output logic [DATA_WIDTH/8-1:0] out_w_strb,
  output logic                    out_w_last,
  output logic [USER_WIDTH-1:0]   out_w_user,
  output logic                    out_w_valid,
  input  logic                    out_w_ready,
  input  logic [ID_WIDTH_OUT-1:0] out_b_id,
  input  logic [1:0]              out_b_resp,
  input  logic [USER_WIDTH-1:0]   out_b_user,
  input  logic                    out_b_valid,
  output logic                    out_b_ready,
  output logic [ID_WIDTH_OUT-1:0] out_ar_id,
  output logic [ADDR_WIDTH-1:0]   out_ar_addr,
  output logic [7:0]              out_ar_len,
  output logic [2:0]              out_ar_size,
  output logic [1:0]              out_ar_burst,
  output logic                    out_ar_lock,
  output logic [3:0]              out_ar_cache,
  output logic [2:0]              out_ar_prot,
  output logic [3:0]              out_ar_qos,
  output logic [3:0]              out_ar_region,
  output logic [USER_WIDTH-1:0]   out_ar_user,
  output logic                    out_ar_valid,
  input  logic                    out_ar_ready,
  input  logic [ID_WIDTH_OUT-1:0] out_r_id,
  input  logic [DATA_WIDTH-1:0]   out_r_data,
  input  logic [1:0]              out_r_resp,
  input  logic                    out_r_last,
  input  logic [USER_WIDTH-1:0]   out_r_user,
  input  logic                    out_r_valid,
  output logic                    out_r_ready
);

  if (!id_width_ok(ID_WIDTH_OUT, TABLE_SIZE)) begin : g_bad_id_width
    $error("axi_id_remapper: ID_WIDTH_OUT cannot index TABLE_SIZE slots");
  end

  logic run, aw_stall, ar_stall;
  assign run = !rst_i;

  axi_id_remap_table #(
    .IN_W(ID_WIDTH_IN), .OUT_W(ID_WIDTH_OUT), .TABLE_SIZE(TABLE_SIZE), .MAX_TXNS(MAX_TXNS)
  ) u_wr_table (
    .clk          (clk_i),
    .rst          (rst_i),
    .issue_valid  (in_aw_valid),
    .issue_ready  (out_aw_ready),
    .issue_id     (in_aw_id),
    .issue_slot   (out_aw_id),
    .stall        (aw_stall),
    .retire_valid (in_b_valid && out_b_ready),
    .retire_slot  (out_b_id),
    .lookup_slot  (out_b_id),
    .lookup_id    (in_b_id)
  );

  // Read slots retire once per burst, on the last beat only.
  axi_id_remap_table #(
    .IN_W(ID_WIDTH_IN), .OUT_W(ID_WIDTH_OUT), .TABLE_SIZE(TABLE_SIZE), .MAX_TXNS(MAX_TXNS)
  ) u_rd_table (
    .clk          (clk_i),
    .rst          (rst_i),
    .issue_valid  (in_ar_valid),
    .issue_ready  (out_ar_ready),
    .issue_id     (in_ar_id),
    .issue_slot   (out_ar_id),
    .stall        (ar_stall),
    .retire_valid (in_r_valid && out_r_ready && out_r_last),
    .retire_slot  (out_r_id),
    .lookup_slot  (out_r_id),
    .lookup_id    (in_r_id)
  );

  assign out_aw_valid = in_aw_valid && !aw_stall && run;
  assign in_aw_ready  = out_aw_ready && !aw_stall && run;
  assign out_ar_valid = in_ar_valid && !ar_stall && run;
  assign in_ar_ready  = out_ar_ready && !ar_stall && run;
  assign out_w_valid  = in_w_valid && run;
  assign in_w_ready   = out_w_ready && run;
  assign in_b_valid   = out_b_valid && run;
  assign out_b_ready  = in_b_ready && run;
  assign in_r_valid   = out_r_valid && run;
  assign out_r_ready  = in_r_ready && run;

  assign out_aw_addr   = in_aw_addr;
  assign out_aw_len    = in_aw_len;
  assign out_aw_size   = in_aw_size;
  assign out_aw_burst  = in_aw_burst;
  assign out_aw_lock   = in_aw_lock;
  assign out_aw_cache  = in_aw_cache;
  assign out_aw_prot   = in_aw_prot;
  assign out_aw_qos    = in_aw_qos;
  assign out_aw_region = in_aw_region;
  assign out_aw_user   = in_aw_user;
  assign out_ar_addr   = in_ar_addr;
  assign out_ar_len    = in_ar_len;
  assign out_ar_size   = in_ar_size;
  assign out_ar_burst  = in_ar_burst;
  assign out_ar_lock   = in_ar_lock;
  assign out_ar_cache  = in_ar_cache;
  assign out_ar_prot   = in_ar_prot;
  assign out_ar_qos    = in_ar_qos;
  assign out_ar_region = in_ar_region;
  assign out_ar_user   = in_ar_user;
  assign out_w_data    = in_w_data;
  assign out_w_strb    = in_w_strb;
  assign out_w_last    = in_w_last;
  assign out_w_user    = in_w_user;
  assign in_b_resp     = out_b_resp;
  assign in_b_user     = out_b_user;
  assign in_r_data     = out_r_data;
  assign in_r_resp     = out_r_resp;
  assign in_r_last     = out_r_last;
  assign in_r_user     = out_r_user;

endmodule

`default_nettype wire

// File: tb/tb_axi_id_remapper.sv
// Directed bench for axi_id_remapper: bench acts as both upstream master and downstream slave.
`default_nettype none

module tb_axi_id_remapper;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  in_aw_id, in_ar_id, in_b_id, in_r_id;
  logic [31:0] in_aw_addr, in_ar_addr, in_w_data, in_r_data;
  logic [7:0]  in_aw_len, in_ar_len;
  logic [2:0]  in_aw_size, in_ar_size, in_aw_prot, in_ar_prot;
  logic [1:0]  in_aw_burst, in_ar_burst, in_b_resp, in_r_resp;
  logic        in_aw_lock, in_ar_lock;
  logic [3:0]  in_aw_cache, in_ar_cache, in_aw_qos, in_ar_qos, in_aw_region, in_ar_region;
  logic [7:0]  in_aw_user, in_ar_user, in_w_user, in_b_user, in_r_user;
  logic [3:0]  in_w_strb;
  logic        in_aw_valid, in_aw_ready, in_w_last, in_w_valid, in_w_ready;
  logic        in_b_valid, in_b_ready, in_ar_valid, in_ar_ready;
  logic        in_r_last, in_r_valid, in_r_ready;
  logic [3:0]  out_aw_id, out_ar_id, out_b_id, out_r_id;
  logic [31:0] out_aw_addr, out_ar_addr, out_w_data, out_r_data;
  logic [7:0]  out_aw_len, out_ar_len;
  logic [2:0]  out_aw_size, out_ar_size, out_aw_prot, out_ar_prot;
  logic [1:0]  out_aw_burst, out_ar_burst, out_b_resp, out_r_resp;
  logic        out_aw_lock, out_ar_lock;
  logic [3:0]  out_aw_cache, out_ar_cache, out_aw_qos, out_ar_qos, out_aw_region, out_ar_region;
  logic [7:0]  out_aw_user, out_ar_user, out_w_user, out_b_user, out_r_user;
  logic [3:0]  out_w_strb;
  logic        out_aw_valid, out_aw_ready, out_w_last, out_w_valid, out_w_ready;
  logic        out_b_valid, out_b_ready, out_ar_valid, out_ar_ready;
  logic        out_r_last, out_r_valid, out_r_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  axi_id_remapper dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_aw_id(in_aw_id), .in_aw_addr(in_aw_addr), .in_aw_len(in_aw_len), .in_aw_size(in_aw_size),
    .in_aw_burst(in_aw_burst), .in_aw_lock(in_aw_lock), .in_aw_cache(in_aw_cache), .in_aw_prot(in_aw_prot),
    .in_aw_qos(in_aw_qos), .in_aw_region(in_aw_region), .in_aw_user(in_aw_user),
    .in_aw_valid(in_aw_valid), .in_aw_ready(in_aw_ready),
    .in_w_data(in_w_data), .in_w_strb(in_w_strb), .in_w_last(in_w_last), .in_w_user(in_w_user),
    .in_w_valid(in_w_valid), .in_w_ready(in_w_ready),
    .in_b_id(in_b_id), .in_b_resp(in_b_resp), .in_b_user(in_b_user), .in_b_valid(in_b_valid), .in_b_ready(in_b_ready),
    .in_ar_id(in_ar_id), .in_ar_addr(in_ar_addr), .in_ar_len(in_ar_len), .in_ar_size(in_ar_size),
    .in_ar_burst(in_ar_burst), .in_ar_lock(in_ar_lock), .in_ar_cache(in_ar_cache), .in_ar_prot(in_ar_prot),
    .in_ar_qos(in_ar_qos), .in_ar_region(in_ar_region), .in_ar_user(in_ar_user),
    .in_ar_valid(in_ar_valid), .in_ar_ready(in_ar_ready),
    .in_r_id(in_r_id), .in_r_data(in_r_data), .in_r_resp(in_r_resp), .in_r_last(in_r_last),
    .in_r_user(in_r_user), .in_r_valid(in_r_valid), .in_r_ready(in_r_ready),
    .out_aw_id(out_aw_id), .out_aw_addr(out_aw_addr), .out_aw_len(out_aw_len), .out_aw_size(out_aw_size),
    .out_aw_burst(out_aw_burst), .out_aw_lock(out_aw_lock), .out_aw_cache(out_aw_cache), .out_aw_prot(out_aw_prot),
    .out_aw_qos(out_aw_qos), .out_aw_region(out_aw_region), .out_aw_user(out_aw_user),
    .out_aw_valid(out_aw_valid), .out_aw_ready(out_aw_ready),
    .out_w_data(out_w_data), .out_w_strb(out_w_strb), .out_w_last(out_w_last), .out_w_user(out_w_user),
    .out_w_valid(out_w_valid), .out_w_ready(out_w_ready),
    .out_b_id(out_b_id), .out_b_resp(out_b_resp), .out_b_user(out_b_user), .out_b_valid(out_b_valid), .out_b_ready(out_b_ready),
    .out_ar_id(out_ar_id), .out_ar_addr(out_ar_addr), .out_ar_len(out_ar_len), .out_ar_size(out_ar_size),
    .out_ar_burst(out_ar_burst), .out_ar_lock(out_ar_lock), .out_ar_cache(out_ar_cache), .out_ar_prot(out_ar_prot),
    .out_ar_qos(out_ar_qos), .out_ar_region(out_ar_region), .out_ar_user(out_ar_user),
    .out_ar_valid(out_ar_valid), .out_ar_ready(out_ar_ready),
    .out_r_id(out_r_id), .out_r_data(out_r_data), .out_r_resp(out_r_resp), .out_r_last(out_r_last),
    .out_r_user(out_r_user), .out_r_valid(out_r_valid), .out_r_ready(out_r_ready)
  );

  // Stimulus helpers only drive and sample; every test checks inline.
  task automatic do_aw(input logic [7:0] id, output logic [3:0] oid, output logic ov);
    in_aw_id = id; in_aw_valid = 1'b1; out_aw_ready = 1'b1;
    #1; oid = out_aw_id; ov = out_aw_valid;
    @(posedge clk_i); #1;
    in_aw_valid = 1'b0; out_aw_ready = 1'b0;
  endtask

  task automatic probe_aw(input logic [7:0] id, output logic [3:0] oid, output logic ov);
    in_aw_id = id; in_aw_valid = 1'b1; out_aw_ready = 1'b0;
    #1; oid = out_aw_id; ov = out_aw_valid;
    in_aw_valid = 1'b0;
  endtask

  task automatic do_b(input logic [3:0] oid, output logic [7:0] iid, output logic v);
    out_b_id = oid; out_b_valid = 1'b1; in_b_ready = 1'b1;
    #1; iid = in_b_id; v = in_b_valid;
    @(posedge clk_i); #1;
    out_b_valid = 1'b0; in_b_ready = 1'b0;
  endtask

  task automatic do_ar(input logic [7:0] id, output logic [3:0] oid, output logic ov);
    in_ar_id = id; in_ar_valid = 1'b1; out_ar_ready = 1'b1;
    #1; oid = out_ar_id; ov = out_ar_valid;
    @(posedge clk_i); #1;
    in_ar_valid = 1'b0; out_ar_ready = 1'b0;
  endtask

  task automatic probe_ar(input logic [7:0] id, output logic [3:0] oid, output logic ov);
    in_ar_id = id; in_ar_valid = 1'b1; out_ar_ready = 1'b0;
    #1; oid = out_ar_id; ov = out_ar_valid;
    in_ar_valid = 1'b0;
  endtask

  task automatic do_r(input logic [3:0] oid, input logic last, output logic [7:0] iid, output logic v);
    out_r_id = oid; out_r_last = last; out_r_valid = 1'b1; in_r_ready = 1'b1;
    #1; iid = in_r_id; v = in_r_valid;
    @(posedge clk_i); #1;
    out_r_valid = 1'b0; in_r_ready = 1'b0; out_r_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    in_aw_valid = 1'b1; in_ar_valid = 1'b1; in_w_valid = 1'b1; out_b_valid = 1'b1; out_r_valid = 1'b1;
    out_aw_ready = 1'b1; out_ar_ready = 1'b1; out_w_ready = 1'b1; in_b_ready = 1'b1; in_r_ready = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++; if (out_aw_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_aw_valid got %b want 0", out_aw_valid); end
    n_cmp++; if (out_ar_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_ar_valid got %b want 0", out_ar_valid); end
    n_cmp++; if (out_w_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_w_valid got %b want 0", out_w_valid); end
    n_cmp++; if (in_b_valid !== 1'b0) begin n_bad++; $display("FAIL rst_in_b_valid got %b want 0", in_b_valid); end
    n_cmp++; if (in_r_valid !== 1'b0) begin n_bad++; $display("FAIL rst_in_r_valid got %b want 0", in_r_valid); end
    n_cmp++; if ({in_aw_ready, in_ar_ready, in_w_ready} !== 3'b000) begin n_bad++; $display("FAIL rst_in_readies got %b want 000", {in_aw_ready, in_ar_ready, in_w_ready}); end
    n_cmp++; if ({out_b_ready, out_r_ready} !== 2'b00) begin n_bad++; $display("FAIL rst_out_readies got %b want 00", {out_b_ready, out_r_ready}); end
    in_aw_valid = 1'b0; in_ar_valid = 1'b0; in_w_valid = 1'b0; out_b_valid = 1'b0; out_r_valid = 1'b0;
    out_aw_ready = 1'b0; out_ar_ready = 1'b0; out_w_ready = 1'b0; in_b_ready = 1'b0; in_r_ready = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_out_of_order_b();
    logic [7:0] ids [4] = '{8'hA7, 8'h3C, 8'h91, 8'h0E};
    logic [3:0] ret [4] = '{4'd2, 4'd0, 4'd1, 4'd3};
    logic [7:0] exp [4] = '{8'h91, 8'hA7, 8'h3C, 8'h0E};
    logic [3:0] oid; logic [7:0] iid; logic v;
    in_aw_addr = 32'hDEAD_0040; #1;
    n_cmp++; if (out_aw_addr !== 32'hDEAD_0040) begin n_bad++; $display("FAIL aw_addr_pass got %h want dead0040", out_aw_addr); end
    for (int i = 0; i < 4; i++) begin
      do_aw(ids[i], oid, v);
      n_cmp++; if (v !== 1'b1 || oid !== 4'(i)) begin n_bad++; $display("FAIL ooo_aw%0d got v=%b id=%0d want v=1 id=%0d", i, v, oid, i); end
      in_w_data = 32'hCAFE_BABE; in_w_last = 1'b1; in_w_valid = 1'b1; out_w_ready = 1'b1; #1;
      n_cmp++; if (out_w_data !== 32'hCAFE_BABE || out_w_valid !== 1'b1 || in_w_ready !== 1'b1) begin
        n_bad++; $display("FAIL ooo_w%0d got data=%h v=%b rdy=%b want cafebabe/1/1", i, out_w_data, out_w_valid, in_w_ready);
      end
      @(posedge clk_i); #1; in_w_valid = 1'b0; out_w_ready = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      do_b(ret[i], iid, v);
      n_cmp++; if (v !== 1'b1 || iid !== exp[i]) begin n_bad++; $display("FAIL ooo_b%0d got v=%b id=%h want v=1 id=%h", i, v, iid, exp[i]); end
    end
  endtask

  task automatic test_table_full();
    logic [3:0] oid; logic [7:0] iid; logic v;
    for (int i = 0; i < 4; i++) begin
      do_aw(8'h10 + 8'(i), oid, v);
      n_cmp++; if (v !== 1'b1 || oid !== 4'(i)) begin n_bad++; $display("FAIL full_aw%0d got v=%b id=%0d want v=1 id=%0d", i, v, oid, i); end
    end
    in_aw_id = 8'h20; in_aw_valid = 1'b1; out_aw_ready = 1'b1; #1;
    n_cmp++; if (out_aw_valid !== 1'b0 || in_aw_ready !== 1'b0) begin n_bad++; $display("FAIL full_stall got v=%b rdy=%b want 0/0", out_aw_valid, in_aw_ready); end
    out_b_id = 4'd1; out_b_valid = 1'b1; in_b_ready = 1'b1; #1;
    n_cmp++; if (in_b_id !== 8'h11) begin n_bad++; $display("FAIL full_b1 got %h want 11", in_b_id); end
    @(posedge clk_i); #1;
    out_b_valid = 1'b0; in_b_ready = 1'b0;
    n_cmp++; if (out_aw_valid !== 1'b1 || out_aw_id !== 4'd1) begin n_bad++; $display("FAIL full_reissue got v=%b id=%0d want v=1 id=1", out_aw_valid, out_aw_id); end
    @(posedge clk_i); #1;
    in_aw_valid = 1'b0; out_aw_ready = 1'b0;
    do_b(4'd0, iid, v); n_cmp++; if (iid !== 8'h10) begin n_bad++; $display("FAIL full_drain0 got %h want 10", iid); end
    do_b(4'd2, iid, v); n_cmp++; if (iid !== 8'h12) begin n_bad++; $display("FAIL full_drain2 got %h want 12", iid); end
    do_b(4'd3, iid, v); n_cmp++; if (iid !== 8'h13) begin n_bad++; $display("FAIL full_drain3 got %h want 13", iid); end
    do_b(4'd1, iid, v); n_cmp++; if (iid !== 8'h20) begin n_bad++; $display("FAIL full_drain1 got %h want 20", iid); end
  endtask

  task automatic test_same_id();
    logic [3:0] oid; logic [7:0] iid; logic v;
    do_aw(8'h5A, oid, v); n_cmp++; if (oid !== 4'd0 || v !== 1'b1) begin n_bad++; $display("FAIL same_aw0 got id=%0d v=%b want 0/1", oid, v); end
    do_aw(8'h5A, oid, v); n_cmp++; if (oid !== 4'd0 || v !== 1'b1) begin n_bad++; $display("FAIL same_aw1 got id=%0d v=%b want 0/1", oid, v); end
    probe_aw(8'h11, oid, v); n_cmp++; if (oid !== 4'd1) begin n_bad++; $display("FAIL same_probe_busy got %0d want 1", oid); end
    do_b(4'd0, iid, v); n_cmp++; if (iid !== 8'h5A) begin n_bad++; $display("FAIL same_b0 got %h want 5a", iid); end
    probe_aw(8'h11, oid, v); n_cmp++; if (oid !== 4'd1) begin n_bad++; $display("FAIL same_probe_kept got %0d want 1", oid); end
    do_b(4'd0, iid, v); n_cmp++; if (iid !== 8'h5A) begin n_bad++; $display("FAIL same_b1 got %h want 5a", iid); end
    probe_aw(8'h11, oid, v); n_cmp++; if (oid !== 4'd0) begin n_bad++; $display("FAIL same_probe_freed got %0d want 0", oid); end
  endtask

  task automatic test_read_burst();
    logic [3:0] oid; logic [7:0] iid; logic v;
    in_ar_len = 8'd3; #1;
    n_cmp++; if (out_ar_len !== 8'd3) begin n_bad++; $display("FAIL rd_len_pass got %0d want 3", out_ar_len); end
    do_ar(8'h33, oid, v); n_cmp++; if (oid !== 4'd0 || v !== 1'b1) begin n_bad++; $display("FAIL rd_ar got id=%0d v=%b want 0/1", oid, v); end
    for (int b = 0; b < 4; b++) begin
      do_r(4'd0, (b == 3), iid, v);
      n_cmp++; if (iid !== 8'h33 || v !== 1'b1) begin n_bad++; $display("FAIL rd_beat%0d got id=%h v=%b want 33/1", b, iid, v); end
      if (b == 2) begin
        probe_ar(8'h44, oid, v); n_cmp++; if (oid !== 4'd1) begin n_bad++; $display("FAIL rd_busy_before_last got %0d want 1", oid); end
      end
    end
    probe_ar(8'h44, oid, v); n_cmp++; if (oid !== 4'd0) begin n_bad++; $display("FAIL rd_freed_after_last got %0d want 0", oid); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] oid; logic [7:0] iid; logic v;
    for (int i = 0; i < 3; i++) begin
      do_aw(8'h01 + 8'(i), oid, v);
      n_cmp++; if (oid !== 4'(i)) begin n_bad++; $display("FAIL midrst_aw%0d got %0d want %0d", i, oid, i); end
    end
    rst_i = 1'b1; @(posedge clk_i); #1; rst_i = 1'b0;
    do_aw(8'h77, oid, v); n_cmp++; if (oid !== 4'd0 || v !== 1'b1) begin n_bad++; $display("FAIL midrst_new got id=%0d v=%b want 0/1", oid, v); end
    probe_aw(8'h78, oid, v); n_cmp++; if (oid !== 4'd1) begin n_bad++; $display("FAIL midrst_next_free got %0d want 1", oid); end
    do_b(4'd0, iid, v); n_cmp++; if (iid !== 8'h77) begin n_bad++; $display("FAIL midrst_b got %h want 77", iid); end
  endtask

  task automatic test_max_txns();
    logic [3:0] oid; logic [7:0] iid; logic v;
    for (int i = 0; i < 8; i++) begin
      do_aw(8'h66, oid, v);
      n_cmp++; if (oid !== 4'd0 || v !== 1'b1) begin n_bad++; $display("FAIL max_aw%0d got id=%0d v=%b want 0/1", i, oid, v); end
    end
    in_aw_id = 8'h66; in_aw_valid = 1'b1; out_aw_ready = 1'b1; #1;
    n_cmp++; if (out_aw_valid !== 1'b0 || in_aw_ready !== 1'b0) begin n_bad++; $display("FAIL max_stall got v=%b rdy=%b want 0/0", out_aw_valid, in_aw_ready); end
    out_b_id = 4'd0; out_b_valid = 1'b1; in_b_ready = 1'b1;
    @(posedge clk_i); #1;
    out_b_valid = 1'b0; in_b_ready = 1'b0;
    n_cmp++; if (out_aw_valid !== 1'b1 || out_aw_id !== 4'd0) begin n_bad++; $display("FAIL max_release got v=%b id=%0d want 1/0", out_aw_valid, out_aw_id); end
    @(posedge clk_i); #1;
    in_aw_valid = 1'b0; out_aw_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_b(4'd0, iid, v);
      n_cmp++; if (iid !== 8'h66) begin n_bad++; $display("FAIL max_drain%0d got %h want 66", i, iid); end
    end
    probe_aw(8'h99, oid, v); n_cmp++; if (oid !== 4'd0) begin n_bad++; $display("FAIL max_freed got %0d want 0", oid); end
  endtask

  task automatic test_issue_retire_same_cycle();
    logic [3:0] oid; logic [7:0] iid; logic v;
    do_aw(8'h42, oid, v); n_cmp++; if (oid !== 4'd0) begin n_bad++; $display("FAIL sim_aw got %0d want 0", oid); end
    in_aw_id = 8'h42; in_aw_valid = 1'b1; out_aw_ready = 1'b1;
    out_b_id = 4'd0; out_b_valid = 1'b1; in_b_ready = 1'b1;
    @(posedge clk_i); #1;
    in_aw_valid = 1'b0; out_aw_ready = 1'b0; out_b_valid = 1'b0; in_b_ready = 1'b0;
    probe_aw(8'h43, oid, v); n_cmp++; if (oid !== 4'd1) begin n_bad++; $display("FAIL sim_slot_kept got %0d want 1", oid); end
    do_b(4'd0, iid, v); n_cmp++; if (iid !== 8'h42) begin n_bad++; $display("FAIL sim_b got %h want 42", iid); end
    probe_aw(8'h43, oid, v); n_cmp++; if (oid !== 4'd0) begin n_bad++; $display("FAIL sim_slot_freed got %0d want 0", oid); end
  endtask

  initial begin
    rst_i = 1'b1;
    in_aw_id = '0; in_aw_addr = '0; in_aw_len = '0; in_aw_size = 3'd2; in_aw_burst = 2'd1; in_aw_lock = 1'b0;
    in_aw_cache = '0; in_aw_prot = '0; in_aw_qos = '0; in_aw_region = '0; in_aw_user = '0; in_aw_valid = 1'b0;
    in_ar_id = '0; in_ar_addr = '0; in_ar_len = '0; in_ar_size = 3'd2; in_ar_burst = 2'd1; in_ar_lock = 1'b0;
    in_ar_cache = '0; in_ar_prot = '0; in_ar_qos = '0; in_ar_region = '0; in_ar_user = '0; in_ar_valid = 1'b0;
    in_w_data = '0; in_w_strb = 4'hF; in_w_last = 1'b0; in_w_user = '0; in_w_valid = 1'b0;
    in_b_ready = 1'b0; in_r_ready = 1'b0;
    out_aw_ready = 1'b0; out_ar_ready = 1'b0; out_w_ready = 1'b0;
    out_b_id = '0; out_b_resp = '0; out_b_user = '0; out_b_valid = 1'b0;
    out_r_id = '0; out_r_data = 32'h0000_1234; out_r_resp = '0; out_r_last = 1'b0; out_r_user = '0; out_r_valid = 1'b0;
    test_reset();
    test_out_of_order_b();
    test_table_full();
    test_same_id();
    test_read_burst();
    test_reset_mid();
    test_max_txns();
    test_issue_retire_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
